// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the RV32I instruction-fetch stage.
//   state_e          : fetch FSM states (BOOT, RUN, HALT), 2-bit encoding
//   NOP_INSTR        : canonical RV32I NOP (addi x0,x0,0) held in IF/ID at reset
//   DEFAULT_RESET_PC : default program counter after reset
//   pc_plus4()       : 32-bit wrap-around sequential PC increment
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: bundles the instruction-memory, redirect and IF/ID handshake
// signals of the fetch stage.
//   imem_addr / imem_instr        : word fetch from combinational instruction memory
//   redirect_valid / redirect_pc  : taken branch/jump from execute
//   id_valid / id_ready           : IF/ID valid/ready handshake
//   id_instr / id_pc / id_pc_plus4: IF/ID payload
//   halted                        : stage is in HALT
//   misalign                      : sticky misaligned-redirect flag, present only
//                                   when IFETCH_MISALIGN_CHECK_EN is defined
// master = the fetch stage, slave = its environment (memory, execute, decode).
interface ifetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misalign;

  modport master (
    output imem_addr, input imem_instr,
    input  redirect_valid, input redirect_pc,
    input  id_ready, output id_valid, output id_instr, output id_pc, output id_pc_plus4,
    output halted, output misalign
  );

  modport slave (
    input  imem_addr, output imem_instr,
    output redirect_valid, output redirect_pc,
    output id_ready, input id_valid, input id_instr, input id_pc, input id_pc_plus4,
    input  halted, input misalign
  );
`else
  modport master (
    output imem_addr, input imem_instr,
    input  redirect_valid, input redirect_pc,
    input  id_ready, output id_valid, output id_instr, output id_pc, output id_pc_plus4,
    output halted
  );

  modport slave (
    input  imem_addr, output imem_instr,
    output redirect_valid, output redirect_pc,
    output id_ready, input id_valid, input id_instr, input id_pc, input id_pc_plus4,
    input  halted
  );
`endif
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with valid/ready semantics.
//   clk, reset      : clock, asynchronous active-low reset
//   load_i          : capture instr_i/pc_i and mark the entry valid
//   flush_i         : discard the held entry (wins over load and hold)
//   ready_i         : downstream accepts the entry this cycle
//   instr_i, pc_i   : word and its PC being captured
//   valid_o, instr_o, pc_o, pc_plus4_o : registered IF/ID entry
module if_id_reg
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else begin
      // A consumed entry drops valid unless a new one replaces it in the same cycle.
      if (flush_i)      valid_q <= 1'b0;
      else if (load_i)  valid_q <= 1'b1;
      else if (ready_i) valid_q <= 1'b0;

      // Payload only moves on a real load so it stays stable while stalled.
      if (load_i && !flush_i) begin
        instr_q    <= instr_i;
        pc_q       <= pc_i;
        pc_plus4_q <= pc_plus4(pc_i);
      end
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: RV32I instruction-fetch stage. Owns the PC, addresses the
// combinational instruction memory and captures the returned word into the
// IF/ID register (if_id_reg) offered to decode over valid/ready.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : ifetch_if.master (imem, redirect, IF/ID handshake, halted, misalign)
// Parameters:
//   RESET_PC   : PC loaded on reset
//   IMEM_WORDS : memory depth in words; fetches at or above IMEM_WORDS*4 halt
// Build option:
//   IFETCH_MISALIGN_CHECK_EN : when defined, a redirect to a non-word-aligned
//   target sets a sticky misalign flag and halts instead of loading the PC.
//   When undefined the low two target bits are cleared on load.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 64
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master bus
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        halted_q;
  logic        id_valid;
  logic        capture_en;
  logic        out_of_range;
  logic        stop;
  logic        load;
  logic        redirect_take;
  logic        redirect_bad;
  logic [31:0] redirect_target;

  assign redirect_take = bus.redirect_valid && (state_q != BOOT);
  assign capture_en    = (state_q == RUN) && (!id_valid || bus.id_ready);
  assign out_of_range  = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);
  assign stop          = capture_en && ((bus.imem_instr == 32'h0) || out_of_range);
  // Redirect has priority over any capture in the same cycle.
  assign load          = capture_en && !stop && !redirect_take;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign redirect_bad    = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_target = bus.redirect_pc;
  assign bus.misalign    = misalign_q;
`else
  assign redirect_bad    = 1'b0;
  assign redirect_target = bus.redirect_pc & ~32'h3;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_take) begin
      if (!redirect_bad) pc_d = redirect_target;
    end else if (load) begin
      pc_d = pc_plus4(pc_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (redirect_take) begin
      if (redirect_bad) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        misalign_q <= 1'b1;
`endif
      end else begin
        state_q  <= RUN;
        halted_q <= 1'b0;
      end
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (stop) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .flush_i    (redirect_take),
    .ready_i    (bus.id_ready),
    .instr_i    (bus.imem_instr),
    .pc_i       (pc_q),
    .valid_o    (id_valid),
    .instr_o    (bus.id_instr),
    .pc_o       (bus.id_pc),
    .pc_plus4_o (bus.id_pc_plus4)
  );

  assign bus.id_valid  = id_valid;
  assign bus.imem_addr = pc_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifetch_if bus_if();

  ifetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [31:0] mem [64];
  // Out-of-range reads return a nonzero word so only the range check can halt.
  assign bus_if.imem_instr = (bus_if.imem_addr[31:8] == 24'h0) ? mem[bus_if.imem_addr[7:2]] : 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.instr = mem[pc[7:2]];
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake (valid && ready seen at the falling edge) pops one entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus_if.id_valid && bus_if.id_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: transfer pc=%h instr=%h, none expected", bus_if.id_pc, bus_if.id_instr);
      end else begin
        e = sb_q.pop_front();
        if (bus_if.id_instr !== e.instr || bus_if.id_pc !== e.pc || bus_if.id_pc_plus4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   bus_if.id_pc, bus_if.id_instr, bus_if.id_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    bus_if.id_ready = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc = 32'h0;
    repeat (3) tick();
    checks++; if (bus_if.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus_if.id_valid); end
    checks++; if (bus_if.id_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", bus_if.id_instr); end
    checks++; if (bus_if.id_pc !== 32'h0 || bus_if.id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h/%h expected 0/0", bus_if.id_pc, bus_if.id_pc_plus4); end
    checks++; if (bus_if.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", bus_if.halted); end
    checks++; if (bus_if.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus_if.imem_addr); end
    push_exp(32'h0);
    push_exp(32'h4);
    reset = 1'b1;
    tick();
    checks++; if (bus_if.id_valid !== 1'b0) begin errors++; $display("FAIL boot_nocap: got valid %b expected 0", bus_if.id_valid); end
    tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_instr !== 32'h0000_0093 || bus_if.id_pc !== 32'h0 || bus_if.id_pc_plus4 !== 32'h4)
      begin errors++; $display("FAIL first_cap: got v=%b i=%h pc=%h pc4=%h expected 1/00000093/0/4", bus_if.id_valid, bus_if.id_instr, bus_if.id_pc, bus_if.id_pc_plus4); end
    tick();
    checks++; if (bus_if.id_instr !== 32'h0010_0113 || bus_if.id_pc !== 32'h4)
      begin errors++; $display("FAIL second_cap: got i=%h pc=%h expected 00100113/4", bus_if.id_instr, bus_if.id_pc); end
    bus_if.id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h4 || bus_if.id_instr !== mem[1] || bus_if.imem_addr !== 32'h8)
        begin errors++; $display("FAIL bp_hold: got v=%b pc=%h i=%h addr=%h expected 1/4/%h/8", bus_if.id_valid, bus_if.id_pc, bus_if.id_instr, bus_if.imem_addr, mem[1]); end
    end
    push_exp(32'h8);
    bus_if.id_ready = 1'b1;
    tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h8 || bus_if.id_instr !== mem[2])
      begin errors++; $display("FAIL bp_resume: got v=%b pc=%h i=%h expected 1/8/%h", bus_if.id_valid, bus_if.id_pc, bus_if.id_instr, mem[2]); end
    bus_if.id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0C;
    tick();
    bus_if.redirect_valid = 1'b0;
    void'(sb_q.pop_front());
    checks++; if (bus_if.id_valid !== 1'b0 || bus_if.imem_addr !== 32'h0C)
      begin errors++; $display("FAIL redir_bubble: got v=%b addr=%h expected 0/0000000c", bus_if.id_valid, bus_if.imem_addr); end
    tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0C || bus_if.id_instr !== mem[3])
      begin errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h expected 1/c/%h", bus_if.id_valid, bus_if.id_pc, bus_if.id_instr, mem[3]); end
    push_exp(32'h0C);
  endtask

  task automatic test_zero_word();
    for (int a = 32'h10; a <= 32'h24; a += 4) push_exp(32'(a));
    bus_if.id_ready = 1'b1;
    for (int i = 0; i < 30 && bus_if.halted !== 1'b1; i++) tick();
    checks++; if (bus_if.halted !== 1'b1 || bus_if.id_valid !== 1'b0 || bus_if.imem_addr !== 32'h28 || bus_if.id_pc !== 32'h24)
      begin errors++; $display("FAIL zero_halt: got h=%b v=%b addr=%h pc=%h expected 1/0/28/24", bus_if.halted, bus_if.id_valid, bus_if.imem_addr, bus_if.id_pc); end
    tick(); tick();
    checks++; if (bus_if.halted !== 1'b1 || bus_if.imem_addr !== 32'h28 || bus_if.id_valid !== 1'b0)
      begin errors++; $display("FAIL zero_stay: got h=%b addr=%h v=%b expected 1/28/0", bus_if.halted, bus_if.imem_addr, bus_if.id_valid); end
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0C;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks++; if (bus_if.halted !== 1'b0 || bus_if.imem_addr !== 32'h0C || bus_if.id_valid !== 1'b0)
      begin errors++; $display("FAIL zero_exit: got h=%b addr=%h v=%b expected 0/c/0", bus_if.halted, bus_if.imem_addr, bus_if.id_valid); end
    push_exp(32'h0C);
    tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0C)
      begin errors++; $display("FAIL zero_resume: got v=%b pc=%h expected 1/c", bus_if.id_valid, bus_if.id_pc); end
    bus_if.id_ready = 1'b0;
  endtask

  task automatic test_out_of_range();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'hF0;
    tick();
    bus_if.redirect_valid = 1'b0;
    void'(sb_q.pop_front());
    checks++; if (bus_if.imem_addr !== 32'hF0 || bus_if.id_valid !== 1'b0)
      begin errors++; $display("FAIL oor_redir: got addr=%h v=%b expected f0/0", bus_if.imem_addr, bus_if.id_valid); end
    for (int a = 32'hF0; a <= 32'hFC; a += 4) push_exp(32'(a));
    bus_if.id_ready = 1'b1;
    for (int i = 0; i < 30 && bus_if.halted !== 1'b1; i++) tick();
    checks++; if (bus_if.halted !== 1'b1 || bus_if.imem_addr !== 32'h100 || bus_if.id_valid !== 1'b0 || bus_if.id_pc !== 32'hFC)
      begin errors++; $display("FAIL oor_halt: got h=%b addr=%h v=%b pc=%h expected 1/100/0/fc", bus_if.halted, bus_if.imem_addr, bus_if.id_valid, bus_if.id_pc); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
    bus_if.id_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus_if.id_valid !== 1'b0 || bus_if.halted !== 1'b0 || bus_if.imem_addr !== 32'h0 || bus_if.id_instr !== 32'h0000_0013)
      begin errors++; $display("FAIL midrst: got v=%b h=%b addr=%h i=%h expected 0/0/0/00000013", bus_if.id_valid, bus_if.halted, bus_if.imem_addr, bus_if.id_instr); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0 || bus_if.imem_addr !== 32'h4)
      begin errors++; $display("FAIL midrst_boot: got v=%b pc=%h addr=%h expected 1/0/4", bus_if.id_valid, bus_if.id_pc, bus_if.imem_addr); end
  endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0E;
    tick();
    checks++; if (bus_if.misalign !== 1'b1 || bus_if.halted !== 1'b1 || bus_if.id_valid !== 1'b0 || bus_if.imem_addr !== 32'h4)
      begin errors++; $display("FAIL misalign_set: got m=%b h=%b v=%b addr=%h expected 1/1/0/4", bus_if.misalign, bus_if.halted, bus_if.id_valid, bus_if.imem_addr); end
    bus_if.redirect_pc = 32'h10;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks++; if (bus_if.misalign !== 1'b1 || bus_if.halted !== 1'b0 || bus_if.imem_addr !== 32'h10)
      begin errors++; $display("FAIL misalign_sticky: got m=%b h=%b addr=%h expected 1/0/10", bus_if.misalign, bus_if.halted, bus_if.imem_addr); end
  endtask
`else
  task automatic test_misalign();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h0E;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks++; if (bus_if.imem_addr !== 32'h0C || bus_if.id_valid !== 1'b0)
      begin errors++; $display("FAIL align_force: got addr=%h v=%b expected c/0", bus_if.imem_addr, bus_if.id_valid); end
    tick();
    checks++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0C)
      begin errors++; $display("FAIL align_fetch: got v=%b pc=%h expected 1/c", bus_if.id_valid, bus_if.id_pc); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0010_0093 + (32'(i) << 7);
    mem[0]  = 32'h0000_0093;
    mem[1]  = 32'h0010_0113;
    mem[10] = 32'h0000_0000;
    bus_if.id_ready = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc = 32'h0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_zero_word();
    test_out_of_range();
    test_mid_reset();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage for the RV32I core. It sits directly upstream of the combinational instruction memory. It owns the program counter, drives the memory word address, and captures the returned word into an IF/ID pipeline register. That register is offered to decode over a valid/ready handshake. The stage handles branch/jump redirects, downstream back-pressure, and a halt on all-zero or out-of-range fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; fetches at or above IMEM_WORDS*4 are out of range.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  taken branch/jump from execute, one-cycle pulse.
- redirect_pc  in  32  redirect target, byte address.
- id_ready  in  1  decode can accept the IF/ID entry this cycle.
- id_valid  out  1  IF/ID entry is valid.
- id_instr  out  32  captured instruction.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- halted  out  1  stage is in HALT.
- misalign  out  1  redirect target not word aligned; only present with the macro.

## Operation
- States: BOOT, RUN, HALT, encoded 2 bits.
- Reset asserted (any time, mid-operation included):
  - state=BOOT, pc=RESET_PC.
  - id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0.
  - halted=0, misalign=0.
- BOOT: one cycle with no capture, which gives memory contents time to settle. The next state is RUN.
- RUN: capture is enabled when !id_valid || id_ready.
  - On a capture, the stage loads id_instr=imem_instr, id_pc=pc, id_pc_plus4=pc+4, and id_valid=1. It also sets pc=pc+4.
  - If capture is not enabled, the PC and IF/ID register hold their values.
  - Stop condition: imem_instr==0 or pc[31:2]>=IMEM_WORDS when capture is enabled.
    - The word is not captured and the PC holds.
    - id_valid clears if id_ready; otherwise the entry already held stays valid until accepted.
    - The next state is HALT.
- HALT: halted=1 and no capture. A pending entry still drains on id_ready, and id_valid clears after the handshake.
- redirect_valid, in any non-BOOT state, has the highest priority:
  - pc=redirect_pc and id_valid=0 (the held entry is discarded even if id_ready=0).
  - The next state is RUN, so a redirect exits HALT.
  - A redirect in BOOT is ignored.
- Handshake: an entry transfers on id_valid && id_ready. Outputs stay stable while id_valid && !id_ready.
- PC arithmetic is 32-bit wrap-around with no exception.

## Timing
- Fetch-to-decode latency is 1 cycle: the word addressed in cycle N appears on id_* in cycle N+1.
- Throughput is 1 instruction/cycle with id_ready held high.
- Redirect in cycle N: imem_addr=redirect_pc in N+1, the target is on id_* in N+2, and id_valid=0 in N+1 (1 bubble).
- After reset deassertion: the first capture is at the 2nd rising edge (BOOT edge, then RUN edge).
- halted rises on the edge that detects the stop condition, and falls on the edge that takes a redirect.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign=1 (sticky until reset) and enters HALT.
  - The PC is not updated and id_valid clears.
- Macro undefined:
  - The misalign port and logic are absent.
  - redirect_pc[1:0] is forced to 0 when loaded into the PC.

## Structure
- The package ifetch_pkg holds:
  - State enum {BOOT, RUN, HALT}.
  - NOP constant 32'h0000_0013.
  - Default RESET_PC.
- Sub-module if_id_reg holds the valid/ready pipeline register (load, flush, hold). PC and FSM logic live in ifetch_stage.

## Test plan
- Reset sequence, RESET_PC=0, id_ready=1, memory words 0x00000093, 0x00100113:
  - Two edges after release: id_valid=1, id_instr=0x00000093, id_pc=0, id_pc_plus4=4.
  - Next edge: id_instr=0x00100113, id_pc=4.
- Back-pressure: id_ready=0 for 3 cycles with id_valid=1 → id_*/imem_addr hold unchanged. On id_ready=1, the next word follows in 1 cycle.
- Redirect: redirect_valid pulse with redirect_pc=0x0C while id_ready=0 → next cycle id_valid=0, imem_addr=0x0C; one cycle later id_pc=0x0C.
- Zero word: word at 0x28 is 0 → no capture at 0x28, halted=1, PC holds at 0x28. A redirect to 0x0C clears halted and fetch resumes.
- Out of range: PC reaches 0x100 with IMEM_WORDS=64 → HALT without capture.
- With IFETCH_MISALIGN_CHECK_EN: redirect_pc=0x0E → misalign=1, halted=1, id_valid=0, and misalign stays 1 through a later redirect to 0x10.
